alu_arbiter: RTL



---
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between N_REQ requesters over valid/ready
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default build is round-robin.
module alu_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [N_REQ-1:0]        req_valid_in,
    output logic [N_REQ-1:0]        req_ready_out,
    input  logic [3*N_REQ-1:0]      req_unit_in,
    input  logic [N_REQ-1:0]        req_op_in,
    input  logic [DATA_W*N_REQ-1:0] req_acc_in,
    input  logic [DATA_W*N_REQ-1:0] req_src_in,
    output logic [N_REQ-1:0]        rsp_valid_out,
    input  logic [N_REQ-1:0]        rsp_ready_in,
    output logic [DATA_W-1:0]       rsp_data_out,
    output logic [2:0]              alu_unit_sel_out,
    output logic                    alu_op_sel_out,
    output logic [DATA_W-1:0]       alu_acc_out,
    output logic [DATA_W-1:0]       alu_src_out,
    input  logic [DATA_W-1:0]       alu_res_in,
    output logic                    busy_out
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    win_q;
    logic [PTR_W-1:0]    win_d;
    logic                found_d;
    logic [2:0]          unit_q;
    logic [2:0]          unit_d;
    logic                op_q;
    logic                op_d;
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   acc_d;
    logic [DATA_W-1:0]   src_q;
    logic [DATA_W-1:0]   src_d;
    logic [N_REQ-1:0]    rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]    rr_ptr_q;
`endif

    always_comb begin
        found_d = 1'b0;
        win_d   = '0;
        unit_d  = '0;
        op_d    = 1'b0;
        acc_d   = '0;
        src_d   = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_d && req_valid_in[i]) begin
                found_d = 1'b1;
                win_d   = PTR_W'(i);
            end
        end
`else
        // Two passes give circular search: first rr_ptr..N_REQ-1, then wrap to 0.
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_d && req_valid_in[i] && (i >= int'(rr_ptr_q))) begin
                found_d = 1'b1;
                win_d   = PTR_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_d && req_valid_in[i]) begin
                found_d = 1'b1;
                win_d   = PTR_W'(i);
            end
        end
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (win_d == PTR_W'(i)) begin
                unit_d = req_unit_in[3*i +: 3];
                op_d   = req_op_in[i];
                acc_d  = req_acc_in[DATA_W*i +: DATA_W];
                src_d  = req_src_in[DATA_W*i +: DATA_W];
            end
        end
    end

    // Gated by reset so no request is acknowledged while the block is held in reset.
    assign req_ready_out = (state_q == IDLE && rst_n_in && found_d)
                           ? (N_REQ'(1) << win_d) : '0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            win_q       <= '0;
            unit_q      <= '0;
            op_q        <= 1'b0;
            acc_q       <= '0;
            src_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        win_q   <= win_d;
                        unit_q  <= unit_d;
                        op_q    <= op_d;
                        acc_q   <= acc_d;
                        src_q   <= src_d;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_data_q  <= alu_res_in;
                    rsp_valid_q <= N_REQ'(1) << win_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    // rsp_valid_q is one-hot on the winner, so other requesters' ready is masked.
                    if (|(rsp_ready_in & rsp_valid_q)) begin
                        rsp_valid_q <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        rr_ptr_q    <= (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);
`endif
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_out    = rsp_valid_q;
    assign rsp_data_out     = rsp_data_q;
    assign alu_unit_sel_out = unit_q;
    assign alu_op_sel_out   = op_q;
    assign alu_acc_out      = acc_q;
    assign alu_src_out      = src_q;
    assign busy_out         = (state_q != IDLE);

endmodule
